// File: rtl/rescale_stream_pkg.sv
// Shared constants and helpers for the multi-lane MAC/ADD-to-image rescaler.
package rescale_stream_pkg;

  // Width of the per-beat shift setting
  localparam int SHIFT_W = 8;

  // Largest value of a signed field iw bits wide
  function automatic longint img_max(input int iw);
    return (longint'(1) << (iw - 1)) - longint'(1);
  endfunction

  // Smallest value of a signed field iw bits wide
  function automatic longint img_min(input int iw);
    return -(longint'(1) << (iw - 1));
  endfunction

  // Shifting past the input width only replicates the sign, so cap it there
  function automatic logic [SHIFT_W-1:0] clamp_shift(
    input logic [SHIFT_W-1:0] shift_in,
    input logic [SHIFT_W-1:0] limit
  );
    return (shift_in > limit) ? limit : shift_in;
  endfunction

endpackage

// File: rtl/rescale_lane.sv
// One lane of the rescaler: round/extend, arithmetic shift, saturate.
// Three register stages sharing the stream-wide advance enable.
module rescale_lane
  import rescale_stream_pkg::*;
#(
  parameter int NUM_WIDTH = 33,
  parameter int IMG_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic [NUM_WIDTH-1:0] i_data,
  input  logic [SHIFT_W-1:0]   i_shift,
  input  logic                 i_round,
  output logic [IMG_WIDTH-1:0] o_data,
  output logic                 o_sat
);

  // One guard bit so the rounding add can never wrap
  localparam int EXT_W = NUM_WIDTH + 1;
  localparam logic signed [EXT_W-1:0] LIM_MAX   = EXT_W'(img_max(IMG_WIDTH));
  localparam logic signed [EXT_W-1:0] LIM_MIN   = EXT_W'(img_min(IMG_WIDTH));
  localparam logic [SHIFT_W-1:0]      SHIFT_LIM = SHIFT_W'(NUM_WIDTH);

  logic [SHIFT_W-1:0]      w_shift_clamped;
  logic signed [EXT_W-1:0] w_ext;
  logic signed [EXT_W-1:0] w_round_add;

  logic signed [EXT_W-1:0] r_s1_val;
  logic [SHIFT_W-1:0]      r_s1_shift;
  logic signed [EXT_W-1:0] r_s2_val;
  logic [IMG_WIDTH-1:0]    r_s3_data;
  logic                    r_s3_sat;

  // Sign-extend the lane and build the half-LSB rounding addend
  always_comb begin
    w_shift_clamped = clamp_shift(i_shift, SHIFT_LIM);
    w_ext           = {i_data[NUM_WIDTH-1], i_data};
    w_round_add     = '0;
    if (i_round && (w_shift_clamped != '0)) begin
      w_round_add = EXT_W'(1) << (w_shift_clamped - 1'b1);
    end
  end

  // Stage 1: capture the rounded value together with this beat's shift
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_val   <= '0;
      r_s1_shift <= '0;
    end else if (i_en) begin
      r_s1_val   <= w_ext + w_round_add;
      r_s1_shift <= w_shift_clamped;
    end
  end

  // Stage 2: arithmetic right shift by the already-clamped amount
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_val <= '0;
    end else if (i_en) begin
      r_s2_val <= r_s1_val >>> r_s1_shift;
    end
  end

  // Stage 3: clamp to the signed image range and flag any clamping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s3_data <= '0;
      r_s3_sat  <= 1'b0;
    end else if (i_en) begin
      if (r_s2_val > LIM_MAX) begin
        r_s3_data <= LIM_MAX[IMG_WIDTH-1:0];
        r_s3_sat  <= 1'b1;
      end else if (r_s2_val < LIM_MIN) begin
        r_s3_data <= LIM_MIN[IMG_WIDTH-1:0];
        r_s3_sat  <= 1'b1;
      end else begin
        r_s3_data <= r_s2_val[IMG_WIDTH-1:0];
        r_s3_sat  <= 1'b0;
      end
    end
  end

  assign o_data = r_s3_data;
  assign o_sat  = r_s3_sat;

endmodule

// File: rtl/rescale_stream.sv
// Multi-lane rescaler with valid/ready flow control. The whole pipe
// advances together on en, so a stall freezes every stage in place.
module rescale_stream
  import rescale_stream_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int NUM_WIDTH = 33,
  parameter int IMG_WIDTH = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [SHIFT_W-1:0]            shift,
  input  logic                          round,
  input  logic                          sat_clr,
  input  logic                          up_val,
  output logic                          up_rdy,
  input  logic [CHANNELS*NUM_WIDTH-1:0] up_data,
  output logic                          dn_val,
  input  logic                          dn_rdy,
  output logic [CHANNELS*IMG_WIDTH-1:0] dn_data,
  output logic [CHANNELS-1:0]           dn_sat,
  output logic [CNT_WIDTH-1:0]          sat_count
);

  logic                 w_en;
  logic                 w_sat_xfer;
  logic                 r_v1;
  logic                 r_v2;
  logic                 r_v3;
  logic [CNT_WIDTH-1:0] r_sat_count;

  // Advance whenever the output slot is empty or being taken
  assign w_en       = dn_rdy | ~r_v3;
  assign up_rdy     = w_en;
  assign dn_val     = r_v3;
  assign w_sat_xfer = r_v3 & dn_rdy & (|dn_sat);
  assign sat_count  = r_sat_count;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
    rescale_lane #(
      .NUM_WIDTH (NUM_WIDTH),
      .IMG_WIDTH (IMG_WIDTH)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .i_en    (w_en),
      .i_data  (up_data[gi*NUM_WIDTH +: NUM_WIDTH]),
      .i_shift (shift),
      .i_round (round),
      .o_data  (dn_data[gi*IMG_WIDTH +: IMG_WIDTH]),
      .o_sat   (dn_sat[gi])
    );
  end

  // Stage valids move with the datapath; an idle input becomes a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else if (w_en) begin
      r_v1 <= up_val;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
    end
  end

  // Count delivered beats with any clamped lane; sticks at all-ones, clear wins
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sat_count <= '0;
    end else if (sat_clr) begin
      r_sat_count <= '0;
    end else if (w_sat_xfer && !(&r_sat_count)) begin
      r_sat_count <= r_sat_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_rescale_stream.sv
// Testbench for rescale_stream: directed literal cases plus a randomized
// stream checked every cycle against an arithmetic reference model.
module tb_rescale_stream;

  localparam int CH = 4;
  localparam int NW = 33;
  localparam int IW = 16;
  localparam int CW = 16;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [7:0]         shift = 8'd0;
  logic               round = 1'b0;
  logic               sat_clr = 1'b0;
  logic               up_val = 1'b0;
  logic               up_rdy;
  logic [CH*NW-1:0]   up_data = '0;
  logic               dn_val;
  logic               dn_rdy = 1'b0;
  logic [CH*IW-1:0]   dn_data;
  logic [CH-1:0]      dn_sat;
  logic [CW-1:0]      sat_count;

  always #5 clk = ~clk;

  rescale_stream #(
    .CHANNELS  (CH),
    .NUM_WIDTH (NW),
    .IMG_WIDTH (IW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .shift     (shift),
    .round     (round),
    .sat_clr   (sat_clr),
    .up_val    (up_val),
    .up_rdy    (up_rdy),
    .up_data   (up_data),
    .dn_val    (dn_val),
    .dn_rdy    (dn_rdy),
    .dn_data   (dn_data),
    .dn_sat    (dn_sat),
    .sat_count (sat_count)
  );

  typedef struct packed {
    logic [CH*IW-1:0] data;
    logic [CH-1:0]    sat;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    n_out = 0;
  int    exp_cnt = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endfunction

  // Reference: value * 2^-shift (floored, optionally +half), clamped; {sat, data}
  function automatic logic [IW:0] model_lane(input logic [NW-1:0] x, input logic [7:0] sh, input logic rnd);
    logic signed [NW-1:0] xs;
    longint v;
    longint vmax;
    longint vmin;
    int s;
    xs = x;
    v = xs;
    s = (int'(sh) > NW) ? NW : int'(sh);
    if (rnd && s > 0) v = v + (longint'(1) << (s - 1));
    v = v >>> s;
    vmax = (longint'(1) << (IW - 1)) - 1;
    vmin = -(longint'(1) << (IW - 1));
    if (v > vmax) return {1'b1, vmax[IW-1:0]};
    if (v < vmin) return {1'b1, vmin[IW-1:0]};
    return {1'b0, v[IW-1:0]};
  endfunction

  function automatic beat_t model_beat(input logic [CH*NW-1:0] d, input logic [7:0] sh, input logic rnd);
    beat_t b;
    logic [IW:0] r;
    for (int k = 0; k < CH; k++) begin
      r = model_lane(d[k*NW +: NW], sh, rnd);
      b.data[k*IW +: IW] = r[IW-1:0];
      b.sat[k] = r[IW];
    end
    return b;
  endfunction

  function automatic logic [NW-1:0] rand_lane();
    logic [NW-1:0] v;
    int unsigned sel;
    sel = $urandom_range(2, 0);
    v = {1'($urandom_range(1, 0)), 32'($urandom)};
    if (sel == 1) v = NW'($signed(v[20:0]));
    else if (sel == 2) v = NW'($signed(v[16:0]));
    return v;
  endfunction

  // Monitor: compare outputs with the model each cycle, then update the model
  initial begin
    beat_t e;
    logic hold;
    logic ev;
    logic [CH*IW-1:0] hd;
    logic [CH-1:0] hs;
    hold = 1'b0;
    hd = '0;
    hs = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        exp_cnt = 0;
        hold = 1'b0;
      end else begin
        check("sat_count", sat_count, exp_cnt);
        check("up_rdy", up_rdy, dn_rdy || !dn_val);
        if (dn_val) begin
          if (exp_q.size() == 0) begin
            check("stale_beat", dn_val, 0);
          end else begin
            check("dn_data", dn_data, exp_q[0].data);
            check("dn_sat", dn_sat, exp_q[0].sat);
          end
          if (hold) begin
            check("hold_data", dn_data, hd);
            check("hold_sat", dn_sat, hs);
          end
        end
        ev = 1'b0;
        if (dn_val && dn_rdy && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          n_out++;
          ev = |e.sat;
        end
        if (sat_clr) exp_cnt = 0;
        else if (ev && exp_cnt != CNT_MAX) exp_cnt++;
        if (up_val && up_rdy) exp_q.push_back(model_beat(up_data, shift, round));
        hold = dn_val && !dn_rdy;
        hd = dn_data;
        hs = dn_sat;
      end
    end
  end

  // Single beat into an idle pipe; checks acceptance, latency and result
  task automatic send_beat(input string name, input logic [CH*NW-1:0] d, input logic [7:0] sh,
                           input logic rnd, input logic [CH*IW-1:0] exp_d, input logic [CH-1:0] exp_s);
    @(posedge clk); #1;
    up_data = d; shift = sh; round = rnd; up_val = 1'b1; dn_rdy = 1'b1;
    @(negedge clk);
    check({name, "_accept"}, up_rdy, 1);
    @(posedge clk); #1;
    up_val = 1'b0;
    @(negedge clk);
    check({name, "_lat1"}, dn_val, 0);
    @(negedge clk);
    check({name, "_lat2"}, dn_val, 0);
    @(negedge clk);
    check({name, "_lat3"}, dn_val, 1);
    check({name, "_data"}, dn_data, exp_d);
    check({name, "_sat"}, dn_sat, exp_s);
    $display("beat %s: data=0x%h sat=%b", name, dn_data, dn_sat);
  endtask

  initial begin
    int sent;
    int base_out;

    // Pin the model to hand-derived results
    check("model_trunc", model_lane(33'h0_0001_2348, 8'd4, 1'b0), 17'h0_1234);
    check("model_round", model_lane(33'h0_0001_2348, 8'd4, 1'b1), 17'h0_1235);
    check("model_posclamp", model_lane(33'h0_0010_0000, 8'd4, 1'b0), 17'h1_7FFF);
    check("model_negclamp", model_lane(33'h1_FFF0_0000, 8'd4, 1'b0), 17'h1_8000);
    check("model_m1_round", model_lane(33'h1_FFFF_FFFF, 8'd4, 1'b1), 17'h0_0000);
    check("model_shift200", model_lane(33'h1_2345_6789, 8'd200, 1'b0), 17'h0_FFFF);

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_dn_val", dn_val, 0);
    check("rst_dn_data", dn_data, 0);
    check("rst_dn_sat", dn_sat, 0);
    check("rst_sat_count", sat_count, 0);
    check("rst_up_rdy", up_rdy, 1);

    // Truncate, clamps and rounding of -1
    send_beat("trunc",
              {33'h1_FFFF_FFFF, 33'h1_FFF0_0000, 33'h0_0010_0000, 33'h0_0001_2348}, 8'd4, 1'b0,
              {16'hFFFF, 16'h8000, 16'h7FFF, 16'h1234}, 4'b0110);
    @(negedge clk);
    check("sat_count_first", sat_count, 1);
    send_beat("round",
              {33'h1_FFFF_FFFF, 33'h1_FFF0_0000, 33'h0_0010_0000, 33'h0_0001_2348}, 8'd4, 1'b1,
              {16'h0000, 16'h8000, 16'h7FFF, 16'h1235}, 4'b0110);
    // Shift of zero never rounds
    send_beat("shift0",
              {33'd5, 33'h1_FFFF_8000, 33'd0, 33'h0_0000_7FFF}, 8'd0, 1'b1,
              {16'h0005, 16'h8000, 16'h0000, 16'h7FFF}, 4'b0000);
    send_beat("shift200",
              {33'd1, 33'h1_0000_0000, 33'h0_7FFF_FFFF, 33'h1_2345_6789}, 8'd200, 1'b0,
              {16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF}, 4'b0000);
    @(negedge clk);
    check("sat_count_two", sat_count, 2);

    // Backpressure: 8 incrementing beats, downstream stalled in cycles 4-8
    sent = 0;
    base_out = n_out;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      dn_rdy = !(c >= 4 && c <= 8);
      up_val = (sent < 8);
      shift = 8'd0;
      round = 1'b0;
      for (int k = 0; k < CH; k++) up_data[k*NW +: NW] = NW'(100 + sent * 4 + k);
      @(negedge clk);
      if (up_val && up_rdy) sent++;
      if (dn_val && !dn_rdy) check("bp_up_rdy_low", up_rdy, 0);
    end
    up_val = 1'b0;
    check("bp_sent", sent, 8);
    check("bp_delivered", n_out - base_out, 8);
    $display("backpressure: sent=%0d delivered=%0d", sent, n_out - base_out);

    // Randomized stream
    for (int c = 0; c < 3000; c++) begin
      int unsigned sel;
      @(posedge clk); #1;
      up_val = ($urandom_range(3, 0) != 0);
      dn_rdy = ($urandom_range(3, 0) != 0);
      round = 1'($urandom_range(1, 0));
      sel = $urandom_range(9, 0);
      shift = (sel == 9) ? 8'd200 : (sel == 8) ? 8'($urandom_range(40, 30)) : 8'($urandom_range(20, 0));
      sat_clr = ($urandom_range(63, 0) == 0);
      for (int k = 0; k < CH; k++) up_data[k*NW +: NW] = rand_lane();
    end
    @(posedge clk); #1;
    up_val = 1'b0;
    dn_rdy = 1'b1;
    sat_clr = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("random_drain", exp_q.size(), 0);
    $display("random: delivered=%0d sat_count=0x%h", n_out, sat_count);

    // Drive the counter to all-ones with saturating beats; it must stick
    @(posedge clk); #1;
    up_data = '0;
    up_data[NW-1:0] = 33'h0_7FFF_FFFF;
    shift = 8'd0;
    round = 1'b0;
    up_val = 1'b1;
    dn_rdy = 1'b1;
    repeat (CNT_MAX + 8) @(posedge clk);
    @(negedge clk);
    check("cnt_all_ones", sat_count, CNT_MAX);
    $display("counter: sat_count=0x%h", sat_count);

    // Clear collides with a saturating transfer; clear wins
    @(posedge clk); #1;
    sat_clr = 1'b1;
    @(negedge clk);
    check("clr_collide_xfer", dn_val && dn_rdy && (|dn_sat), 1);
    @(posedge clk); #1;
    sat_clr = 1'b0;
    @(negedge clk);
    check("clr_wins", sat_count, 0);

    // Reset with three beats in flight
    @(posedge clk); #1;
    up_val = 1'b0;
    dn_rdy = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    dn_rdy = 1'b1;
    @(negedge clk);
    check("flush_dn_val", dn_val, 0);
    check("flush_dn_data", dn_data, 0);
    check("flush_sat_count", sat_count, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("flush_no_stale", dn_val, 0);
    end
    $display("reset flush: dn_val=%0b", dn_val);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
